// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage with register file, load-use
// scoreboard and a valid/ready ID/EX pipeline register.
// Optional feature macro: ID_PERF_CNT_EN (adds stall/flush performance counters).
module id_stage_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_inst,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [XLEN-1:0]          if_imm,
  input  logic [CTRL_W-1:0]        if_ctrl,
  input  logic                     if_uses_rs1,
  input  logic                     if_uses_rs2,
  input  logic                     if_mem_read,
  input  logic                     if_reg_write,
  input  logic                     flush,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_imm,
  output logic [XLEN-1:0]          ex_rs1_data,
  output logic [XLEN-1:0]          ex_rs2_data,
  output logic [$clog2(NREG)-1:0]  ex_rs1,
  output logic [$clog2(NREG)-1:0]  ex_rs2,
  output logic [$clog2(NREG)-1:0]  ex_rd,
  output logic [CTRL_W-1:0]        ex_ctrl,
  output logic                     ex_mem_read,
  output logic                     ex_reg_write,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt,
`endif
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [XLEN-1:0]          wb_data
);

  localparam int unsigned AW    = $clog2(NREG);
  localparam int unsigned CNT_W = 3;

  logic [XLEN-1:0]  rf [NREG];
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [AW-1:0]    rd;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [CNT_W-1:0] sb_cnt;
  logic [AW-1:0]    sb_rd;
  logic             hz;
  logic             advance;
  logic             accept;
  logic             load_issue;
  logic             unused_inst;

  // Register indices sit at fixed instruction positions; only the low AW bits matter.
  assign rs1         = if_inst[15 +: AW];
  assign rs2         = if_inst[20 +: AW];
  assign rd          = if_inst[7 +: AW];
  assign unused_inst = ^if_inst;

  // Operand read: x0 is hard zero, a same-cycle writeback is forwarded.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) begin
      if (wb_we && (wb_rd == rs1)) rs1_data = wb_data;
      else                         rs1_data = rf[rs1];
    end
    if (rs2 != '0) begin
      if (wb_we && (wb_rd == rs2)) rs2_data = wb_data;
      else                         rs2_data = rf[rs2];
    end
  end

  // Stall only when a used operand matches an outstanding load destination.
  assign hz = (sb_cnt != '0) && (sb_rd != '0) &&
              ((if_uses_rs1 && (rs1 == sb_rd)) || (if_uses_rs2 && (rs2 == sb_rd)));

  assign advance    = !ex_valid || ex_ready;
  assign if_ready   = !hz && advance;
  assign accept     = if_valid && if_ready && !flush;
  assign load_issue = accept && if_mem_read && if_reg_write && (rd != '0);

  // Architectural register file, x0 never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[AW'(i)] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // ID/EX pipeline register: flush > advance (capture or bubble) > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (advance) begin
      ex_valid <= accept;
      if (accept) begin
        ex_pc        <= if_pc;
        ex_imm       <= if_imm;
        ex_rs1_data  <= rs1_data;
        ex_rs2_data  <= rs2_data;
        ex_rs1       <= rs1;
        ex_rs2       <= rs2;
        ex_rd        <= rd;
        ex_ctrl      <= if_ctrl;
        ex_mem_read  <= if_mem_read;
        ex_reg_write <= if_reg_write;
      end else begin
        ex_mem_read  <= 1'b0;
        ex_reg_write <= 1'b0;
      end
    end
  end

  // Load-use scoreboard: newest load wins, counts down while EX advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_cnt <= '0;
      sb_rd  <= '0;
    end else if (flush) begin
      sb_cnt <= '0;
      sb_rd  <= '0;
    end else if (load_issue) begin
      sb_cnt <= CNT_W'(LOAD_LAT);
      sb_rd  <= rd;
    end else if ((sb_cnt != '0) && ex_ready) begin
      sb_cnt <= sb_cnt - CNT_W'(1);
    end
  end

`ifdef ID_PERF_CNT_EN
  // Free-running stall and flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (if_valid && !if_ready && !flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush)                           perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
module tb_id_stage_pipe;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_imm;
  logic [15:0] if_ctrl;
  logic        if_uses_rs1;
  logic        if_uses_rs2;
  logic        if_mem_read;
  logic        if_reg_write;
  logic        flush;
  logic        ex_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        if_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl;
  logic        ex_mem_read;
  logic        ex_reg_write;

  logic        d3_if_ready;
  logic        d3_ex_valid;
  logic [31:0] d3_ex_pc;
  logic [31:0] unused_d3_imm;
  logic [31:0] unused_d3_rs1_data;
  logic [31:0] unused_d3_rs2_data;
  logic [4:0]  unused_d3_rs1;
  logic [4:0]  unused_d3_rs2;
  logic [4:0]  unused_d3_rd;
  logic [15:0] unused_d3_ctrl;
  logic        unused_d3_mem_read;
  logic        unused_d3_reg_write;

`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] unused_d3_stall;
  logic [31:0] unused_d3_flush;
`endif

  int checks = 0;
  int errors = 0;

  id_stage_pipe u_dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .if_imm(if_imm), .if_ctrl(if_ctrl), .if_uses_rs1(if_uses_rs1), .if_uses_rs2(if_uses_rs2),
    .if_mem_read(if_mem_read), .if_reg_write(if_reg_write), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
`ifdef ID_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  id_stage_pipe #(.LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(d3_if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .if_imm(if_imm), .if_ctrl(if_ctrl), .if_uses_rs1(if_uses_rs1), .if_uses_rs2(if_uses_rs2),
    .if_mem_read(if_mem_read), .if_reg_write(if_reg_write), .flush(flush),
    .ex_valid(d3_ex_valid), .ex_ready(ex_ready), .ex_pc(d3_ex_pc), .ex_imm(unused_d3_imm),
    .ex_rs1_data(unused_d3_rs1_data), .ex_rs2_data(unused_d3_rs2_data),
    .ex_rs1(unused_d3_rs1), .ex_rs2(unused_d3_rs2), .ex_rd(unused_d3_rd),
    .ex_ctrl(unused_d3_ctrl), .ex_mem_read(unused_d3_mem_read),
    .ex_reg_write(unused_d3_reg_write),
`ifdef ID_PERF_CNT_EN
    .perf_stall_cnt(unused_d3_stall), .perf_flush_cnt(unused_d3_flush),
`endif
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; imm and ctrl are derived from pc so payload capture is visible.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic rw);
    if_valid     = v;
    if_pc        = pc;
    if_imm       = pc + 32'h1000;
    if_ctrl      = pc[15:0] ^ 16'hA5A5;
    if_inst      = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    if_uses_rs1  = u1;
    if_uses_rs2  = u2;
    if_mem_read  = mr;
    if_reg_write = rw;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    wb_we = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #2;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_if_ready", if_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Seed x5 via writeback, then stream three instructions
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1111_1111;
    tick();
    wb_we = 1'b0;
    drive(1, 32'h100, 5'd1, 5'd0, 5'd0, 0, 0, 0, 1);
    tick();
    check("s1_ex_valid", ex_valid, 1);
    check("s1_ex_pc", ex_pc, 32'h100);
    check("s1_ex_imm", ex_imm, 32'h1100);
    check("s1_ex_ctrl", ex_ctrl, 16'hA4A5);
    drive(1, 32'h104, 5'd2, 5'd5, 5'd0, 1, 0, 0, 1);
    tick();
    check("s2_ex_pc", ex_pc, 32'h104);
    check("s2_x5_read", ex_rs1_data, 32'h1111_1111);
    check("s2_ex_rs1", ex_rs1, 5);
    drive(1, 32'h108, 5'd3, 5'd0, 5'd0, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_ex_pc", ex_pc, 0);
    check("arst_ex_rs1_data", ex_rs1_data, 0);
    check("arst_ex_rd", ex_rd, 0);
    check("arst_ex_reg_write", ex_reg_write, 0);
    check("arst_ex_ctrl", ex_ctrl, 0);
    #2 rst = 1'b1;
    drive(1, 32'h10C, 5'd3, 5'd5, 5'd0, 1, 0, 0, 1);
    tick();
    check("post_rst_pc", ex_pc, 32'h10C);
    check("post_rst_x5", ex_rs1_data, 0);

    // Writeback bypass
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    drive(1, 32'h200, 5'd9, 5'd5, 5'd0, 1, 0, 0, 1);
    tick();
    check("byp_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);
    check("byp_ex_rd", ex_rd, 9);
    wb_rd = 5'd0; wb_data = 32'hCAFE_F00D;
    drive(1, 32'h204, 5'd9, 5'd0, 5'd5, 1, 1, 0, 1);
    tick();
    check("byp_x0_rs1", ex_rs1_data, 0);
    check("byp_rf_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    check("byp_ex_rs2", ex_rs2, 5);
    wb_we = 1'b0;

    // Load-use: lw x7 then add x8,x7,x1
    drive(1, 32'h300, 5'd7, 5'd1, 5'd0, 1, 0, 1, 1);
    tick();
    check("lu_ld_mem_read", ex_mem_read, 1);
    check("lu_ld_rd", ex_rd, 7);
    drive(1, 32'h304, 5'd8, 5'd7, 5'd1, 1, 1, 0, 1);
    #1;
    check("lu1_stall", if_ready, 0);
    check("lu3_stall0", d3_if_ready, 0);
    tick();
    check("lu1_bubble", ex_valid, 0);
    check("lu1_bubble_rw", ex_reg_write, 0);
    check("lu1_ready", if_ready, 1);
    check("lu3_bubble1", d3_ex_valid, 0);
    check("lu3_stall1", d3_if_ready, 0);
    tick();
    check("lu1_issue_valid", ex_valid, 1);
    check("lu1_issue_pc", ex_pc, 32'h304);
    check("lu1_issue_rd", ex_rd, 8);
    check("lu3_bubble2", d3_ex_valid, 0);
    check("lu3_stall2", d3_if_ready, 0);
    tick();
    check("lu3_bubble3", d3_ex_valid, 0);
    check("lu3_ready", d3_if_ready, 1);
    tick();
    check("lu3_issue_valid", d3_ex_valid, 1);
    check("lu3_issue_pc", d3_ex_pc, 32'h304);
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick();

    // Load followed by a consumer that does not read the loaded register
    drive(1, 32'h400, 5'd7, 5'd1, 5'd0, 1, 0, 1, 1);
    tick();
    drive(1, 32'h404, 5'd11, 5'd7, 5'd2, 0, 1, 0, 1);
    #1;
    check("nouse1_ready", if_ready, 1);
    check("nouse3_ready", d3_if_ready, 1);
    tick();
    check("nouse1_pc", ex_pc, 32'h404);
    check("nouse3_pc", d3_ex_pc, 32'h404);
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Back-pressure
    drive(1, 32'h500, 5'd3, 5'd0, 5'd0, 0, 0, 0, 1);
    tick();
    check("bp_a_pc", ex_pc, 32'h500);
    ex_ready = 1'b0;
    drive(1, 32'h504, 5'd4, 5'd0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_if_ready", if_ready, 0);
      tick();
      check("bp_hold_valid", ex_valid, 1);
      check("bp_hold_pc", ex_pc, 32'h500);
      check("bp_hold_rd", ex_rd, 3);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", if_ready, 1);
    tick();
    check("bp_b_pc", ex_pc, 32'h504);
    check("bp_b_rd", ex_rd, 4);
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick();
    check("bp_no_dup", ex_valid, 0);

    // Flush with a load outstanding and an incoming dependent instruction
    drive(1, 32'h600, 5'd6, 5'd1, 5'd0, 1, 0, 1, 1);
    tick();
    check("fl_ld_valid", ex_valid, 1);
    drive(1, 32'h604, 5'd10, 5'd6, 5'd0, 1, 0, 0, 1);
    flush = 1'b1;
    tick();
    check("fl_ex_valid", ex_valid, 0);
    check("fl_ex_mem_read", ex_mem_read, 0);
    check("fl_ex_reg_write", ex_reg_write, 0);
    check("fl3_ex_valid", d3_ex_valid, 0);
    flush = 1'b0;
    drive(1, 32'h608, 5'd12, 5'd6, 5'd0, 1, 0, 0, 1);
    #1;
    check("fl_sb_clear1", if_ready, 1);
    check("fl_sb_clear3", d3_if_ready, 1);
    tick();
    check("fl_next_pc", ex_pc, 32'h608);
    check("fl3_next_pc", d3_ex_pc, 32'h608);
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick();

`ifdef ID_PERF_CNT_EN
    // Two stall cycles and one flush from a fresh reset
    #2 rst = 1'b0;
    #1;
    check("perf_rst_stall", perf_stall_cnt, 0);
    check("perf_rst_flush", perf_flush_cnt, 0);
    #2 rst = 1'b1;
    drive(1, 32'h700, 5'd1, 5'd0, 5'd0, 0, 0, 0, 1);
    tick();
    ex_ready = 1'b0;
    drive(1, 32'h704, 5'd2, 5'd0, 5'd0, 0, 0, 0, 1);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex_ready = 1'b1;
    drive(0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick();
    check("perf_stall_cnt", perf_stall_cnt, 2);
    check("perf_flush_cnt", perf_flush_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
